// File: rtl/cpu_fetch_unit.sv
// ---------------------------------------------------------------------------
// cpu_fetch_unit
//
// Front-end fetch stage. Owns the PC, issues one instruction-memory request
// at a time, looks the PC up in the branch predictor, pre-decodes the
// returned instruction to choose the next PC, and presents
// {pc, instr, pred_taken} to decode from a single output register (the slot).
// A redirect from execute flushes the slot and restarts fetch.
//
// Handshakes:
//   imem: a request is accepted in a cycle where imem_req && imem_gnt.
//         Exactly one response (imem_rvalid) follows, in order.
//   out : a transfer occurs in a cycle where out_valid && out_ready. While
//         out_valid && !out_ready every out_* signal is held stable.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_req/addr   fetch request and its address (the PC)
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response valid, imem_rdata the instruction
//   bp_addr         predictor lookup address (always the PC)
//   bp_taken        predictor answer, combinational from bp_addr
//   redirect        flush, restart fetch at redirect_pc
//   out_valid/ready decode handshake
//   out_pc/instr    fetched instruction and its PC
//   out_pred_taken  fetch followed a taken prediction for this instruction
// ---------------------------------------------------------------------------
module cpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] bp_addr,
    input  logic        bp_taken,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_pred_taken
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic [31:0] pc;

    // Pre-decode results
    logic [6:0]  opcode;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] next_pc;
    logic        next_pred;
    logic        load_slot;
    logic        slot_free;

    assign opcode = imem_rdata[6:0];
    assign imm_b  = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                     imem_rdata[11:8], 1'b0};
    assign imm_j  = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                     imem_rdata[30:21], 1'b0};

    always_comb begin
        next_pc   = pc + 32'd4;
        next_pred = 1'b0;
        if (opcode == 7'b1101111) begin
            next_pc   = pc + imm_j;
            next_pred = 1'b1;
        end else if (opcode == 7'b1100011 && bp_taken) begin
            next_pc   = pc + imm_b;
            next_pred = 1'b1;
        end
    end

    // A new request may only go out if its response is guaranteed a place
    // in the slot: the slot is empty or is handing off this very cycle.
    assign slot_free = !out_valid || out_ready;
    assign imem_req  = !rst && (state == ST_REQ) && slot_free;
    assign imem_addr = pc;
    assign bp_addr   = pc;

    assign load_slot = (state == ST_WAIT) && imem_rvalid && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            out_valid      <= 1'b0;
            out_pc         <= 32'h0;
            out_instr      <= NOP;
            out_pred_taken <= 1'b0;
        end else begin
            // Output slot
            if (redirect) begin
                out_valid <= 1'b0;
            end else if (load_slot) begin
                out_valid      <= 1'b1;
                out_pc         <= pc;
                out_instr      <= imem_rdata;
                out_pred_taken <= next_pred;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // PC and request FSM
            if (redirect) begin
                pc <= redirect_pc;
                case (state)
                    // A request granted alongside the redirect still owes
                    // a response, which must be thrown away.
                    ST_REQ:  state <= (imem_req && imem_gnt) ? ST_DROP : ST_REQ;
                    ST_WAIT: state <= imem_rvalid ? ST_REQ : ST_DROP;
                    // The single outstanding response is consumed whether
                    // or not another redirect arrives with it.
                    ST_DROP: state <= imem_rvalid ? ST_REQ : ST_DROP;
                    default: state <= ST_REQ;
                endcase
            end else begin
                case (state)
                    ST_REQ: begin
                        if (imem_req && imem_gnt) state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            pc    <= next_pc;
                            state <= ST_REQ;
                        end
                    end
                    ST_DROP: begin
                        if (imem_rvalid) state <= ST_REQ;
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_fetch_unit
//
// Directed bench for cpu_fetch_unit with RESET_PC = 0x100. Inputs are driven
// on the falling edge; outputs are sampled 1ns later, well away from the
// rising edge where the DUT updates. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_cpu_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'hFE00_08E3; // branch offset -16
    localparam logic [31:0] JAL8 = 32'h0080_006F; // jump offset +8

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] bp_addr;
    logic        bp_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;

    int n_vec;
    int n_err;

    cpu_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .bp_addr        (bp_addr),
        .bp_taken       (bp_taken),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pred_taken (out_pred_taken)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then let combinational logic settle.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Full fetch: request granted at exp_addr, response one cycle later.
    // Leaves the bench one cycle after rvalid with the slot just loaded.
    task automatic fetch_one(input logic [31:0] exp_addr,
                             input logic [31:0] instr, input logic bp,
                             input logic [31:0] exp_next,
                             input logic exp_pred);
        imem_gnt = 1'b1;
        #1;
        check("req", {31'b0, imem_req}, 32'd1);
        check("addr", imem_addr, exp_addr);
        next_cycle();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        bp_taken    = bp;
        #1;
        check("bp_addr", bp_addr, exp_addr);
        check("wait_no_req", {31'b0, imem_req}, 32'd0);
        next_cycle();
        imem_rvalid = 1'b0;
        bp_taken    = 1'b0;
        check("out_valid", {31'b0, out_valid}, 32'd1);
        check("out_pc", out_pc, exp_addr);
        check("out_instr", out_instr, instr);
        check("out_pred", {31'b0, out_pred_taken}, {31'b0, exp_pred});
        check("next_addr", imem_addr, exp_next);
    endtask

    // Redirect while in REQ without a grant.
    task automatic redirect_req(input logic [31:0] target);
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = target;
        next_cycle();
        redirect = 1'b0;
        check("redir_valid", {31'b0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, target);
        check("redir_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        bp_taken    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        #1;

        // Reset values
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, NOP);
        check("rst_pred", {31'b0, out_pred_taken}, 32'd0);
        check("rst_addr", imem_addr, 32'h100);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Sequential NOP stream, one instruction every two cycles
        fetch_one(32'h100, NOP, 1'b0, 32'h104, 1'b0);
        fetch_one(32'h104, NOP, 1'b0, 32'h108, 1'b0);
        fetch_one(32'h108, NOP, 1'b0, 32'h10C, 1'b0);

        // Conditional branch, predicted taken then not taken
        redirect_req(32'h10);
        fetch_one(32'h10, BEQ, 1'b1, 32'h00, 1'b1);
        fetch_one(32'h00, BEQ, 1'b0, 32'h04, 1'b0);

        // JAL is always taken regardless of the predictor
        redirect_req(32'h20);
        fetch_one(32'h20, JAL8, 1'b0, 32'h28, 1'b1);

        // Back-pressure: slot full, decode stalls for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_pc", out_pc, 32'h20);
            check("stall_instr", out_instr, JAL8);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        out_ready = 1'b1;
        fetch_one(32'h28, NOP, 1'b0, 32'h2C, 1'b0);

        // Redirect during WAIT; response arrives two cycles later
        imem_gnt = 1'b1;
        next_cycle();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        next_cycle();
        redirect = 1'b0;
        check("drop_req0", {31'b0, imem_req}, 32'd0);
        next_cycle();
        check("drop_req1", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = JAL8;
        next_cycle();
        imem_rvalid = 1'b0;
        check("drop_valid", {31'b0, out_valid}, 32'd0);
        check("drop_next_req", {31'b0, imem_req}, 32'd1);
        check("drop_next_addr", imem_addr, 32'h400);

        // Redirect coincident with rvalid: discarded, no DROP cycle
        imem_gnt = 1'b1;
        next_cycle();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = JAL8;
        redirect    = 1'b1;
        redirect_pc = 32'h800;
        next_cycle();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        check("coin_valid", {31'b0, out_valid}, 32'd0);
        check("coin_req", {31'b0, imem_req}, 32'd1);
        check("coin_addr", imem_addr, 32'h800);

        // Redirect flushes a full, stalled slot
        fetch_one(32'h800, NOP, 1'b0, 32'h804, 1'b0);
        out_ready = 1'b0;
        redirect_req(32'h900);
        out_ready = 1'b1;

        // Redirect in REQ together with a grant -> response dropped
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hA00;
        next_cycle();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        check("gnt_drop_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = NOP;
        next_cycle();
        imem_rvalid = 1'b0;
        check("gnt_drop_valid", {31'b0, out_valid}, 32'd0);
        check("gnt_drop_addr", imem_addr, 32'hA00);
        check("gnt_drop_req1", {31'b0, imem_req}, 32'd1);

        // PC wraps modulo 2^32
        redirect_req(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, NOP, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of WAIT, then a stale response in REQ
        imem_gnt = 1'b1;
        next_cycle();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_pc", out_pc, 32'h0);
        check("mid_rst_instr", out_instr, NOP);
        check("mid_rst_pred", {31'b0, out_pred_taken}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h100);
        next_cycle();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = JAL8;
        #1;
        check("stale_req", {31'b0, imem_req}, 32'd1);
        next_cycle();
        imem_rvalid = 1'b0;
        check("stale_valid", {31'b0, out_valid}, 32'd0);
        check("stale_addr", imem_addr, 32'h100);
        check("stale_req_held", {31'b0, imem_req}, 32'd1);
        fetch_one(32'h100, NOP, 1'b0, 32'h104, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
